// File: rtl/dcpu_boot_ctrl.sv
// dcpu_boot_ctrl: dCPU boot/run sequencer; streams a program into memory, then runs the CPU under a cycle watchdog
// Optional feature macro: DCPU_BOOT_CHECKSUM_EN (ld_last byte becomes a mod-256 checksum, not written to memory)
// Ports: clk, rst (async, active-high); start;
//   loader stream ld_valid/ld_data/ld_last -> ld_ready;
//   CPU side cpu_stop/cpu_R/cpu_W/cpu_addr/cpu_data -> cpu_rst;
//   memory port mem_R/mem_W/mem_addr/mem_wdata;
//   status busy/done/err/load_count/run_cycles.
module dcpu_boot_ctrl #(
  parameter logic [7:0] LOAD_BASE  = 8'd0,
  parameter int         MAX_CYCLES = 4096,
  parameter int         CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             ld_valid,
  input  logic [7:0]       ld_data,
  input  logic             ld_last,
  output logic             ld_ready,
  output logic             cpu_rst,
  input  logic             cpu_stop,
  input  logic             cpu_R,
  input  logic             cpu_W,
  input  logic [7:0]       cpu_addr,
  input  logic [7:0]       cpu_data,
  output logic             mem_R,
  output logic             mem_W,
  output logic [7:0]       mem_addr,
  output logic [7:0]       mem_wdata,
  output logic             busy,
  output logic             done,
  output logic [1:0]       err,
  output logic [8:0]       load_count,
  output logic [CNT_W-1:0] run_cycles
);
  localparam logic [2:0] S_IDLE = 3'd0, S_LOAD = 3'd1, S_REL = 3'd2, S_RUN = 3'd3, S_DONE = 3'd4, S_ERR = 3'd5;
  // Separate unsaturated watchdog counter so the trip point is independent of CNT_W.
  localparam int WD_W = $clog2(MAX_CYCLES + 1);
  logic [2:0]      state, state_nx;
  logic [WD_W-1:0] wd;
  logic            xfer, wr, full, trip, restart;
  assign xfer    = state == S_LOAD && ld_valid;
`ifdef DCPU_BOOT_CHECKSUM_EN
  logic [7:0] sum;
  assign wr      = xfer && !ld_last;
`else
  assign wr      = xfer;
`endif
  assign full    = wr && load_count == 9'd255;
  assign trip    = wd == WD_W'(MAX_CYCLES - 1);
  assign restart = start && (state == S_IDLE || state == S_DONE || state == S_ERR);
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE, S_DONE, S_ERR: state_nx = start ? S_LOAD : state;
`ifdef DCPU_BOOT_CHECKSUM_EN
      S_LOAD: state_nx = (xfer && ld_last) ? ((sum == ld_data) ? S_REL : S_ERR) : (full ? S_REL : S_LOAD);
`else
      S_LOAD: state_nx = (full || (xfer && ld_last)) ? S_REL : S_LOAD;
`endif
      S_REL:  state_nx = S_RUN;
      S_RUN:  state_nx = cpu_stop ? S_DONE : (trip ? S_ERR : S_RUN);
      default: state_nx = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      cpu_rst    <= 1'b1;
      err        <= 2'b00;
      load_count <= 9'd0;
      run_cycles <= '0;
      wd         <= '0;
`ifdef DCPU_BOOT_CHECKSUM_EN
      sum        <= 8'd0;
`endif
    end else begin
      state   <= state_nx;
      cpu_rst <= state_nx != S_RUN;
      if (restart) begin
        load_count <= 9'd0;
        run_cycles <= '0;
        err        <= 2'b00;
        wd         <= '0;
`ifdef DCPU_BOOT_CHECKSUM_EN
        sum        <= 8'd0;
`endif
      end
      if (wr) load_count <= load_count + 9'd1;
`ifdef DCPU_BOOT_CHECKSUM_EN
      if (wr) sum <= sum + ld_data;
      if (xfer && ld_last && sum != ld_data) err <= 2'b10;
`endif
      if (state == S_RUN) begin
        wd <= wd + 1'b1;
        if (run_cycles != '1) run_cycles <= run_cycles + 1'b1;
        if (!cpu_stop && trip) err <= 2'b01;
      end
    end
  end
  assign ld_ready  = state == S_LOAD;
  assign busy      = state == S_LOAD || state == S_REL || state == S_RUN;
  assign done      = state == S_DONE;
  assign mem_R     = ld_ready | cpu_rst | cpu_R;
  assign mem_W     = ld_ready ? !wr : (cpu_rst | cpu_W);
  assign mem_addr  = ld_ready ? LOAD_BASE + load_count[7:0] : cpu_addr;
  assign mem_wdata = ld_ready ? ld_data : cpu_data;
endmodule

// File: tb/tb_dcpu_boot_ctrl.sv
// tb_dcpu_boot_ctrl: directed bench for dcpu_boot_ctrl with a cycle-level reference model and a memory image
module tb_dcpu_boot_ctrl;
  localparam logic [7:0] BASE = 8'hFE;
  localparam int MAXC = 16;
  localparam int CW = 4;
  localparam int P_IDLE = 0, P_LOAD = 1, P_REL = 2, P_RUN = 3, P_DONE = 4, P_ERR = 5;
  logic clk = 0, rst = 1, start = 0, ld_valid = 0, ld_last = 0, cpu_stop = 0, cpu_R = 1, cpu_W = 1;
  logic [7:0] ld_data = 0, cpu_addr = 0, cpu_data = 0;
  logic ld_ready, cpu_rst, mem_R, mem_W, busy, done;
  logic [7:0] mem_addr, mem_wdata;
  logic [1:0] err;
  logic [8:0] load_count;
  logic [CW-1:0] run_cycles;
  int errors = 0, total = 0;
  logic chk_on = 0;
  logic [7:0] mem [256];
  int ph = P_IDLE, cnt = 0, cyc = 0, rl = 0;
  logic [7:0] sum = 0;
  logic [1:0] e = 0;
  logic in_load, wr_x, mrst;
  logic [7:0] xaddr;

  dcpu_boot_ctrl #(.LOAD_BASE(BASE), .MAX_CYCLES(MAXC), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last),
    .ld_ready(ld_ready), .cpu_rst(cpu_rst), .cpu_stop(cpu_stop), .cpu_R(cpu_R), .cpu_W(cpu_W),
    .cpu_addr(cpu_addr), .cpu_data(cpu_data), .mem_R(mem_R), .mem_W(mem_W), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .busy(busy), .done(done), .err(err), .load_count(load_count), .run_cycles(run_cycles)
  );

  always #5 clk = ~clk;
  always @(posedge clk) if (!mem_W) mem[mem_addr] <= mem_wdata;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] x);
    total++;
    if (a !== x) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, x, $time);
    end
  endtask

  // Reference model: phase plus counters, advanced from the sampled inputs on each edge.
  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      ph = P_IDLE; cnt = 0; cyc = 0; rl = 0; sum = 0; e = 0;
    end else case (ph)
      P_IDLE, P_DONE, P_ERR: if (start) begin ph = P_LOAD; cnt = 0; cyc = 0; rl = 0; sum = 0; e = 0; end
      P_LOAD: if (ld_valid) begin
`ifdef DCPU_BOOT_CHECKSUM_EN
        if (ld_last) begin
          if (sum == ld_data) ph = P_REL; else begin ph = P_ERR; e = 2'b10; end
        end else begin
          cnt++; sum = sum + ld_data;
          if (cnt == 256) ph = P_REL;
        end
`else
        cnt++;
        if (ld_last || cnt == 256) ph = P_REL;
`endif
      end
      P_REL: ph = P_RUN;
      P_RUN: begin
        rl++;
        cyc = (rl > 2**CW - 1) ? 2**CW - 1 : rl;
        if (cpu_stop) ph = P_DONE;
        else if (rl == MAXC) begin ph = P_ERR; e = 2'b01; end
      end
      default: ph = P_IDLE;
    endcase
  end

  initial forever begin
    @(negedge clk);
    if (chk_on) begin
      in_load = ph == P_LOAD;
`ifdef DCPU_BOOT_CHECKSUM_EN
      wr_x = in_load && ld_valid && !ld_last;
`else
      wr_x = in_load && ld_valid;
`endif
      mrst = ph != P_RUN;
      xaddr = BASE + cnt[7:0];
      chk("ld_ready", 32'(ld_ready), 32'(in_load));
      chk("busy", 32'(busy), 32'(ph == P_LOAD || ph == P_REL || ph == P_RUN));
      chk("done", 32'(done), 32'(ph == P_DONE));
      chk("err", 32'(err), 32'(e));
      chk("cpu_rst", 32'(cpu_rst), 32'(mrst));
      chk("load_count", 32'(load_count), 32'(cnt));
      chk("run_cycles", 32'(run_cycles), 32'(cyc));
      chk("mem_R", 32'(mem_R), 32'((in_load || mrst) ? 1'b1 : cpu_R));
      chk("mem_W", 32'(mem_W), 32'(in_load ? !wr_x : (mrst ? 1'b1 : cpu_W)));
      chk("mem_addr", 32'(mem_addr), 32'(in_load ? xaddr : cpu_addr));
      chk("mem_wdata", 32'(mem_wdata), 32'(in_load ? ld_data : cpu_data));
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic last);
    ld_valid = 1; ld_data = d; ld_last = last;
    tick();
    ld_valid = 0; ld_last = 0;
  endtask

  task automatic pulse_start();
    start = 1;
    tick();
    start = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    tick(2);
    chk_on = 1;
    rst = 0;
    chk("rst_cpu_rst", 32'(cpu_rst), 1);
    chk("rst_ld_ready", 32'(ld_ready), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_load_count", 32'(load_count), 0);
    chk("rst_run_cycles", 32'(run_cycles), 0);
    chk("rst_err", 32'(err), 0);
    cpu_R = 0; cpu_W = 0; cpu_addr = 8'h33;
    tick();
    chk("idle_strobe_mask", 32'({mem_R, mem_W}), 32'b11);
    cpu_R = 1; cpu_W = 1;
    // Load 1 with a stall cycle in the middle.
    pulse_start();
    send(8'hC0, 0);
    tick();
    send(8'h05, 0);
`ifdef DCPU_BOOT_CHECKSUM_EN
    send(8'hC5, 1);
    chk("load1_count", 32'(load_count), 2);
`else
    send(8'hCC, 1);
    chk("load1_count", 32'(load_count), 3);
    chk("load1_mem00", 32'(mem[8'h00]), 32'hCC);
`endif
    chk("load1_memFE", 32'(mem[8'hFE]), 32'hC0);
    chk("load1_memFF", 32'(mem[8'hFF]), 32'h05);
    chk("release_cpu_rst", 32'(cpu_rst), 1);
    tick();
    chk("run_cpu_rst_low", 32'(cpu_rst), 0);
    // Run 1: CPU traffic passes through, stop on run cycle 10.
    cpu_R = 0;
    for (int i = 1; i <= 9; i++) begin
      cpu_addr = 8'h80 + 8'(i); cpu_data = 8'(i * 3); cpu_W = (i != 4);
      tick();
    end
    cpu_W = 1;
    chk("cpu_write_mem84", 32'(mem[8'h84]), 32'h0C);
    cpu_stop = 1;
    tick();
    cpu_stop = 0;
    chk("run1_done", 32'(done), 1);
    chk("run1_cycles", 32'(run_cycles), 10);
    chk("run1_cpu_rst", 32'(cpu_rst), 1);
    chk("run1_err", 32'(err), 0);
    tick();
    cpu_R = 1;
    // Load 2 across the address wrap, then let the watchdog trip.
    pulse_start();
    chk("start_clears_done", 32'(done), 0);
    chk("start_clears_cycles", 32'(run_cycles), 0);
    send(8'h11, 0); send(8'h22, 0); send(8'h33, 0);
`ifdef DCPU_BOOT_CHECKSUM_EN
    send(8'h66, 1);
    chk("load2_count", 32'(load_count), 3);
`else
    send(8'h44, 1);
    chk("load2_count", 32'(load_count), 4);
    chk("load2_mem01", 32'(mem[8'h01]), 32'h44);
`endif
    chk("load2_memFE", 32'(mem[8'hFE]), 32'h11);
    chk("load2_memFF", 32'(mem[8'hFF]), 32'h22);
    chk("load2_mem00", 32'(mem[8'h00]), 32'h33);
    tick(16);
    chk("wd_not_early", 32'(err), 0);
    chk("wd_cycles_15", 32'(run_cycles), 15);
    tick();
    chk("wd_err", 32'(err), 32'b01);
    chk("wd_cycles_sat", 32'(run_cycles), 15);
    chk("wd_cpu_rst", 32'(cpu_rst), 1);
    chk("wd_done", 32'(done), 0);
    // Load 3: full 256 bytes without ld_last; stop coincides with watchdog trip.
    pulse_start();
    chk("start_clears_err", 32'(err), 0);
    for (int i = 0; i < 256; i++) send(8'(i), 0);
    chk("full_count", 32'(load_count), 256);
    chk("full_release_busy", 32'(busy), 1);
    chk("full_release_ready", 32'(ld_ready), 0);
    chk("full_memFD", 32'(mem[8'hFD]), 32'hFF);
    chk("full_memFE", 32'(mem[8'hFE]), 32'h00);
    tick(16);
    cpu_stop = 1;
    tick();
    cpu_stop = 0;
    chk("tie_done", 32'(done), 1);
    chk("tie_err", 32'(err), 0);
    // Load 4: gaps, then asynchronous reset mid-load.
    pulse_start();
    send(8'hAA, 0);
    tick(3);
    send(8'hBB, 0);
    tick(2);
    rst = 1;
    #1;
    chk("abort_ready", 32'(ld_ready), 0);
    chk("abort_cpu_rst", 32'(cpu_rst), 1);
    chk("abort_busy", 32'(busy), 0);
    tick();
    rst = 0;
    chk("abort_memFE", 32'(mem[8'hFE]), 32'hAA);
    chk("abort_memFF", 32'(mem[8'hFF]), 32'hBB);
`ifdef DCPU_BOOT_CHECKSUM_EN
    pulse_start();
    send(8'h01, 0); send(8'h02, 0); send(8'h03, 1);
    chk("cs_ok_busy", 32'(busy), 1);
    chk("cs_ok_err", 32'(err), 0);
    tick();
    chk("cs_ok_run", 32'(cpu_rst), 0);
    cpu_stop = 1;
    tick();
    cpu_stop = 0;
    pulse_start();
    send(8'h01, 0); send(8'h02, 0); send(8'h04, 1);
    chk("cs_bad_err", 32'(err), 32'b10);
    tick(3);
    chk("cs_bad_cpu_rst", 32'(cpu_rst), 1);
    chk("cs_bad_busy", 32'(busy), 0);
`endif
    tick(2);
    $display("Result: errors=%0d of %0d checks", errors, total);
    $finish;
  end
endmodule
